// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock: FSM encoding, time-of-day limits, range check.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alarm_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  localparam logic [4:0] HH_MAX = 5'd23;
  localparam logic [5:0] MM_MAX = 6'd59;
  localparam logic [5:0] SS_MAX = 6'd59;

  // True when an hour/minute pair is a legal time of day.
  function automatic logic hm_valid(input logic [4:0] h, input logic [5:0] m);
    return (h <= HH_MAX) && (m <= MM_MAX);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_HZ cycles (one per second).
// Latency: tick asserts while the count sits at CLK_HZ-1; clr restarts the count on the next edge.
// Backpressure: none; free-running, clr is honoured every cycle.
// Ports: CLK clock, RST sync active-high reset, clr restart strobe, tick one-cycle pulse.
module tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock: time-of-day counter, alarm register and IDLE/RING/SNOOZE buzzer FSM.
// Latency: time updates on the tick edge; enable rises one edge after the tick that reaches the alarm time.
// Backpressure: none; strobes and pulses are sampled every cycle, outputs are registers.
// Ports: CLK/RST (sync active-high); set_time/set_alarm load from set_hh/set_mm;
//        alarm_on arms; snooze/stop pulses; enable buzzer; state_o FSM state; hh/mm/ss time.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_S     = 60
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               set_time,
  input  logic               set_alarm,
  input  logic [4:0]         set_hh,
  input  logic [5:0]         set_mm,
  input  logic               alarm_on,
  input  logic               snooze,
  input  logic               stop,
  output logic               enable,
  output logic [STATE_W-1:0] state_o,
  output logic [4:0]         hh,
  output logic [5:0]         mm,
  output logic [5:0]         ss
);

  localparam int SNZ_LIM = SNOOZE_MIN * 60;
  // At least 10 bits, widened when a long snooze would not fit.
  localparam int SNZ_W   = ($clog2(SNZ_LIM + 1) > 10) ? $clog2(SNZ_LIM + 1) : 10;

  logic             tick;
  logic             time_load;
  logic             alarm_load;
  logic             match_q;
  logic             ring_done;
  logic             snz_done;
  logic [4:0]       alarm_hh;
  logic [5:0]       alarm_mm;
  logic [4:0]       hh_nx;
  logic [5:0]       mm_nx;
  logic [5:0]       ss_nx;
  logic [7:0]       ring_cnt;
  logic [SNZ_W-1:0] snz_cnt;
  state_t           state;
  state_t           state_nx;

  // Out-of-range set values are dropped entirely, including the prescaler clear.
  assign time_load  = set_time  && hm_valid(set_hh, set_mm);
  assign alarm_load = set_alarm && hm_valid(set_hh, set_mm);

  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (time_load),
    .tick (tick)
  );

  // Time one second ahead; used both for the tick update and for match detection.
  always_comb begin
    hh_nx = hh;
    mm_nx = mm;
    ss_nx = ss + 6'd1;
    if (ss == SS_MAX) begin
      ss_nx = 6'd0;
      mm_nx = mm + 6'd1;
      if (mm == MM_MAX) begin
        mm_nx = 6'd0;
        hh_nx = (hh == HH_MAX) ? 5'd0 : hh + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hh       <= 5'd0;
      mm       <= 6'd0;
      ss       <= 6'd0;
      alarm_hh <= 5'd0;
      alarm_mm <= 6'd0;
      match_q  <= 1'b0;
    end else begin
      if (alarm_load) begin
        alarm_hh <= set_hh;
        alarm_mm <= set_mm;
      end
      if (time_load) begin
        hh <= set_hh;
        mm <= set_mm;
        ss <= 6'd0;
      end else if (tick) begin
        hh <= hh_nx;
        mm <= mm_nx;
        ss <= ss_nx;
      end
      // Only a tick that lands on hh:mm:00 counts; a set_time onto the alarm minute does not.
      match_q <= tick && !time_load && (ss_nx == 6'd0) &&
                 (mm_nx == alarm_mm) && (hh_nx == alarm_hh);
    end
  end

  // Counters are compared one short of the limit so the exit happens on the limit tick itself.
  assign ring_done = tick && (ring_cnt == 8'(RING_S - 1));
  assign snz_done  = tick && (snz_cnt == SNZ_W'(SNZ_LIM - 1));

  always_comb begin
    state_nx = state;
    if (!alarm_on) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (match_q) state_nx = S_RING;
        S_RING: begin
          if (stop || ring_done) state_nx = S_IDLE;
          else if (snooze)       state_nx = S_SNOOZE;
        end
        S_SNOOZE: begin
          if (stop)          state_nx = S_IDLE;
          else if (snz_done) state_nx = S_RING;
        end
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      enable   <= 1'b0;
      ring_cnt <= 8'd0;
      snz_cnt  <= '0;
    end else begin
      state  <= state_nx;
      enable <= (state_nx == S_RING);
      if (state_nx == S_RING && state != S_RING) begin
        ring_cnt <= 8'd0;
      end else if (state == S_RING && tick) begin
        ring_cnt <= ring_cnt + 8'd1;
      end
      if (state_nx == S_SNOOZE && state != S_SNOOZE) begin
        snz_cnt <= '0;
      end else if (state == S_SNOOZE && tick) begin
        snz_cnt <= snz_cnt + SNZ_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl with CLK_HZ=4, SNOOZE_MIN=1, RING_S=3.
// Expected snapshots {state, enable, hh, mm, ss} are queued with the stimulus, popped at sample points.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alarm_ctrl;

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  RING   = 2'd1;
  localparam logic [1:0]  SNZ    = 2'd2;
  localparam logic [19:0] M_ALL  = 20'hFFFFF;
  localparam logic [19:0] M_FSM  = 20'hE0000;
  localparam logic [19:0] M_TIME = 20'h1FFFF;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       set_time = 1'b0;
  logic       set_alarm = 1'b0;
  logic [4:0] set_hh = 5'd0;
  logic [5:0] set_mm = 6'd0;
  logic       alarm_on = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       enable;
  logic [1:0] state_o;
  logic [4:0] hh;
  logic [5:0] mm;
  logic [5:0] ss;

  int checks = 0;
  int failures = 0;

  string       name_q[$];
  logic [19:0] val_q[$];
  logic [19:0] mask_q[$];

  always #5 CLK = ~CLK;

  alarm_ctrl #(.CLK_HZ(4), .SNOOZE_MIN(1), .RING_S(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .set_time  (set_time),
    .set_alarm (set_alarm),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .alarm_on  (alarm_on),
    .snooze    (snooze),
    .stop      (stop),
    .enable    (enable),
    .state_o   (state_o),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss)
  );

  function automatic logic [19:0] snap();
    return {state_o, enable, hh, mm, ss};
  endfunction

  function automatic void push_exp(input string nm, input logic [1:0] st, input logic en,
                                   input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                                   input logic [19:0] msk);
    name_q.push_back(nm);
    mask_q.push_back(msk);
    val_q.push_back({st, en, h, m, s} & msk);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_set_time(input logic [4:0] h, input logic [5:0] m);
    set_hh = h; set_mm = m; set_time = 1'b1;
    step(1);
    set_time = 1'b0;
  endtask

  task automatic do_set_alarm(input logic [4:0] h, input logic [5:0] m);
    set_hh = h; set_mm = m; set_alarm = 1'b1;
    step(1);
    set_alarm = 1'b0;
  endtask

  // Alarm 00:01, time 00:00:00; returns one edge after the 60th tick, i.e. just as ringing starts.
  task automatic ring_up();
    alarm_on = 1'b1;
    do_set_alarm(5'd0, 6'd1);
    do_set_time(5'd0, 6'd0);
    step(241);
  endtask

  task automatic test_reset();
    string nm; logic [19:0] ev, em;
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    push_exp("reset_state", IDLE, 1'b0, 5'd0, 6'd0, 6'd0, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    push_exp("reset_no_early_tick", IDLE, 1'b0, 5'd0, 6'd0, 6'd0, M_ALL);
    step(3);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    push_exp("reset_first_tick", IDLE, 1'b0, 5'd0, 6'd0, 6'd1, M_TIME);
    step(1);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
  endtask

  task automatic test_rollover();
    string nm; logic [19:0] ev, em;
    do_set_time(5'd23, 6'd59);
    push_exp("roll_235959", IDLE, 1'b0, 5'd23, 6'd59, 6'd59, M_ALL);
    push_exp("roll_000000", IDLE, 1'b0, 5'd0, 6'd0, 6'd0, M_ALL);
    push_exp("roll_000001", IDLE, 1'b0, 5'd0, 6'd0, 6'd1, M_ALL);
    step(236);
    for (int i = 0; i < 3; i++) begin
      nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
      if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
      step(4);
    end
  endtask

  task automatic test_ring_timeout();
    string nm; logic [19:0] ev, em;
    int gaps[4] = '{240, 1, 10, 1};
    alarm_on = 1'b1;
    do_set_alarm(5'd0, 6'd1);
    do_set_time(5'd0, 6'd0);
    push_exp("match_edge_no_enable", IDLE, 1'b0, 5'd0, 6'd1, 6'd0, M_ALL);
    push_exp("enable_rises",         RING, 1'b1, 5'd0, 6'd1, 6'd0, M_ALL);
    push_exp("still_ringing",        RING, 1'b1, 5'd0, 6'd1, 6'd2, M_ALL);
    push_exp("ring_timeout",         IDLE, 1'b0, 5'd0, 6'd1, 6'd3, M_ALL);
    for (int i = 0; i < 4; i++) begin
      step(gaps[i]);
      nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
      if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    end
  endtask

  task automatic test_snooze();
    string nm; logic [19:0] ev, em;
    ring_up();
    push_exp("snz_ringing", RING, 1'b1, 5'd0, 6'd0, 6'd0, M_FSM);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    snooze = 1'b1; step(1); snooze = 1'b0;
    push_exp("snz_entered", SNZ, 1'b0, 5'd0, 6'd0, 6'd0, M_FSM);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    step(100);
    snooze = 1'b1; step(1); snooze = 1'b0;
    push_exp("snz_before_limit", SNZ, 1'b0, 5'd0, 6'd0, 6'd0, M_FSM);
    push_exp("snz_reringing",    RING, 1'b1, 5'd0, 6'd0, 6'd0, M_FSM);
    step(136);
    for (int i = 0; i < 2; i++) begin
      nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
      if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
      step(1);
    end
    stop = 1'b1; step(1); stop = 1'b0;
    push_exp("snz_stop", IDLE, 1'b0, 5'd0, 6'd0, 6'd0, M_FSM);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
  endtask

  task automatic test_stop_and_snooze();
    string nm; logic [19:0] ev, em;
    ring_up();
    stop = 1'b1; snooze = 1'b1; step(1); stop = 1'b0; snooze = 1'b0;
    push_exp("stop_beats_snooze", IDLE, 1'b0, 5'd0, 6'd0, 6'd0, M_FSM);
    push_exp("stays_idle",        IDLE, 1'b0, 5'd0, 6'd0, 6'd0, M_FSM);
    for (int i = 0; i < 2; i++) begin
      nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
      if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
      step(8);
    end
  endtask

  task automatic test_invalid_and_set_minute();
    string nm; logic [19:0] ev, em;
    do_set_alarm(5'd24, 6'd0);
    do_set_time(5'd12, 6'd34);
    push_exp("set_time_1234", IDLE, 1'b0, 5'd12, 6'd34, 6'd0, M_ALL);
    push_exp("bad_minute_ign", IDLE, 1'b0, 5'd12, 6'd34, 6'd0, M_ALL);
    push_exp("bad_hour_ign",   IDLE, 1'b0, 5'd12, 6'd34, 6'd0, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    do_set_time(5'd5, 6'd60);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    do_set_time(5'd24, 6'd0);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    // Alarm must still be 00:01 after the rejected 24:00.
    do_set_time(5'd0, 6'd0);
    step(241);
    push_exp("alarm_kept_rings", RING, 1'b1, 5'd0, 6'd1, 6'd0, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    do_set_time(5'd0, 6'd0);
    push_exp("set_time_in_ring", RING, 1'b1, 5'd0, 6'd0, 6'd0, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    stop = 1'b1; step(1); stop = 1'b0;
    do_set_time(5'd0, 6'd1);
    step(20);
    push_exp("set_on_alarm_min_no_ring", IDLE, 1'b0, 5'd0, 6'd1, 6'd5, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
  endtask

  task automatic test_alarm_off();
    string nm; logic [19:0] ev, em;
    ring_up();
    alarm_on = 1'b0;
    step(1);
    push_exp("alarm_off_idle", IDLE, 1'b0, 5'd0, 6'd1, 6'd0, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    alarm_on = 1'b1;
  endtask

  task automatic test_reset_mid_ring();
    string nm; logic [19:0] ev, em;
    ring_up();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    push_exp("rst_mid_ring", IDLE, 1'b0, 5'd0, 6'd0, 6'd0, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    // Reset alarm is 00:00, so crossing midnight must ring.
    do_set_time(5'd23, 6'd59);
    step(241);
    push_exp("rst_alarm_0000", RING, 1'b1, 5'd0, 6'd0, 6'd0, M_ALL);
    nm = name_q.pop_front(); ev = val_q.pop_front(); em = mask_q.pop_front(); checks++;
    if ((snap() & em) !== ev) begin failures++; $display("FAIL %s got=%h want=%h", nm, snap() & em, ev); end
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_ring_timeout();
    test_snooze();
    test_stop_and_snooze();
    test_invalid_and_set_minute();
    test_alarm_off();
    test_reset_mid_ring();
    checks++;
    if (name_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained got=%0d want=0", name_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock cycles per second.
REQ-002 SHALL have parameter SNOOZE_MIN, default 5, snooze length in minutes (1..59).
REQ-003 SHALL have parameter RING_S, default 60, maximum ring duration in seconds (1..255).
REQ-004 SHALL have port CLK, input, 1, system clock; the design has one clock.
REQ-005 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port set_time, input, 1, single-cycle strobe that loads time-of-day from set_hh/set_mm, with seconds cleared.
REQ-007 SHALL have port set_alarm, input, 1, single-cycle strobe that loads the alarm time from set_hh/set_mm.
REQ-008 SHALL have port set_hh, input, 5, hour value, 0..23.
REQ-009 SHALL have port set_mm, input, 6, minute value, 0..59.
REQ-010 SHALL have port alarm_on, input, 1, level; arms the alarm.
REQ-011 SHALL have port snooze, input, 1, debounced single-cycle pulse.
REQ-012 SHALL have port stop, input, 1, debounced single-cycle pulse.
REQ-013 SHALL have port enable, output, 1, buzzer enable driven to the downstream buzzer stage.
REQ-014 SHALL have port state_o, output, 2, current FSM state.
REQ-015 SHALL have ports hh/mm/ss, outputs of 5/6/6 bits, current time-of-day.

Function
REQ-016 SHALL run a prescaler counting 0..CLK_HZ-1 and pulse tick for one cycle when the count is CLK_HZ-1; the prescaler wraps to 0 on that cycle.
REQ-017 SHALL advance ss on tick; at ss=59, ss goes to 0 and mm increments; at mm=59, mm goes to 0 and hh increments; 23:59:59 SHALL wrap to 00:00:00.
REQ-018 SHALL, on set_time, load hh/mm, clear ss and clear the prescaler on the next edge; set_time SHALL override tick in the same cycle.
REQ-019 SHALL ignore set_time and set_alarm when set_hh>23 or set_mm>59; the registers SHALL be left unchanged.
REQ-020 SHALL define a match event as a tick that makes the time equal to alarm_hh:alarm_mm:00; a set_time landing on the alarm minute SHALL NOT be a match event.
REQ-021 SHALL implement an FSM with states IDLE=0, RING=1, SNOOZE=2.
  - IDLE to RING: match event while alarm_on=1.
  - RING to IDLE: stop, or ring-second counter reaching RING_S.
  - RING to SNOOZE: snooze.
  - SNOOZE to RING: snooze-second counter reaching SNOOZE_MIN*60.
  - SNOOZE to IDLE: stop.
  - Any state to IDLE: alarm_on=0.
REQ-022 SHALL drive enable=1 exactly while state is RING, registered; enable SHALL rise on the edge after the matching tick edge.
REQ-023 SHALL clear the ring-second counter on entry to RING and increment it on each tick while in RING.
REQ-024 SHALL clear the snooze counter (10 bits) on entry to SNOOZE and increment it on each tick while in SNOOZE.
REQ-025 SHALL give priority stop > snooze when both arrive in the same cycle; the FSM SHALL go to IDLE.
REQ-026 SHALL ignore snooze in IDLE or SNOOZE; the snooze count SHALL NOT restart.
REQ-027 SHALL ignore match events while in RING or SNOOZE.
REQ-028 SHALL NOT alter the FSM state on set_alarm or set_time issued during RING or SNOOZE.

Reset
REQ-029 SHALL, on RST=1 at a CLK edge, clear the prescaler and the hh, mm and ss registers.
REQ-030 SHALL, on RST=1 at a CLK edge, set alarm time to 00:00, state to IDLE, enable to 0, and both duration counters to 0.
REQ-031 SHALL give RST priority over every other input, including when asserted mid-RING.

Structure
REQ-032 SHALL place state encodings, time limit constants (23, 59) and the state width in a shared package alarm_pkg.
REQ-033 SHALL implement the prescaler and tick generation as sub-module tick_gen (CLK, RST, clr, tick).
REQ-034 SHALL use only fully registered outputs.

Verification (CLK_HZ=4, SNOOZE_MIN=1, RING_S=3)
REQ-035 Case 1: set_time 23:59, wait 60 ticks -> hh:mm:ss = 00:00:00, then 00:00:01 on the next tick.
REQ-036 Case 2: set_alarm 00:01, alarm_on=1, set_time 00:00, 60 ticks -> enable=1 one cycle after the 60th tick; enable=0 after 3 further ticks with state IDLE.
REQ-037 Case 3: ringing, pulse snooze -> state=SNOOZE and enable=0 next cycle; after 60 ticks enable=1 again; then stop -> IDLE.
REQ-038 Case 4: ringing, stop and snooze in the same cycle -> state IDLE and enable=0.
REQ-039 Case 5: set_alarm 24:00 -> alarm registers unchanged; set_time equal to the alarm minute -> no ring.
REQ-040 Case 6: RST asserted mid-RING -> next cycle enable=0, state IDLE, time 00:00:00.
